excitation_src: RTL and testbench

EXCITATION_SRC -- requirements
Module: excitation_src

---
 rtl/excitation_src.sv | 119 +++++++++++
 tb/tb_excitation_src.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/excitation_src.sv
// Pitch/noise excitation generator for an all-pole synthesis filter.
// Emits one sample per accepted tick and handshakes it to the filter via start/filt_done.
module excitation_src (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tick,
  input  logic [7:0]  period_in,
  input  logic [7:0]  amp_in,
  input  logic        param_load,
  input  logic        filt_done,
  input  logic        overrun_clr,
  output logic [15:0] sig_out,
  output logic        start,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK, BUSY} state_t;

  state_t      state, state_next;
  logic [7:0]  shadow_period, shadow_amp;
  logic [7:0]  active_period, active_amp;
  logic [7:0]  pitch_cnt;
  logic [16:0] lfsr;

  logic        accept;
  logic        boundary;
  logic [7:0]  new_period, new_amp;
  logic [15:0] amp64, amp16;
  logic [15:0] sig_next;
  logic [7:0]  cnt_next;
  logic [16:0] lfsr_next;

  assign accept   = (state == IDLE) && sample_tick && filt_done;
  assign boundary = (pitch_cnt == 8'd0) || (active_period == 8'd0);

  // At a boundary the shadow values become active and shape this very sample.
  assign new_period = boundary ? shadow_period : active_period;
  assign new_amp    = boundary ? shadow_amp    : active_amp;
  assign amp64      = {2'b00, new_amp, 6'b000000};
  assign amp16      = {4'b0000, new_amp, 4'b0000};

  always_comb begin
    sig_next = 16'd0;
    cnt_next = pitch_cnt - 8'd1;
    if (boundary) begin
      if (new_period != 8'd0) begin
        sig_next = amp64;
        cnt_next = new_period - 8'd1;
      end else begin
        sig_next = lfsr[0] ? amp16 : (16'd0 - amp16);
        cnt_next = 8'd0;
      end
    end
  end

  // Maximal-length taps never reach zero from a nonzero seed; the guard covers upsets.
  assign lfsr_next = (lfsr == 17'd0) ? 17'h00001 : {lfsr[15:0], lfsr[16] ^ lfsr[13]};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = ACK;
      ACK:     if (!filt_done) state_next = BUSY;
      BUSY:    if (filt_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_period <= 8'd0;
      shadow_amp    <= 8'd0;
    end else if (param_load) begin
      shadow_period <= period_in;
      shadow_amp    <= amp_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_period <= 8'd0;
      active_amp    <= 8'd0;
      pitch_cnt     <= 8'd0;
      sig_out       <= 16'd0;
      lfsr          <= 17'h00001;
    end else if (accept) begin
      active_period <= new_period;
      active_amp    <= new_amp;
      pitch_cnt     <= cnt_next;
      sig_out       <= sig_next;
      lfsr          <= lfsr_next;
    end
  end

  // A dropped tick takes priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (sample_tick && !accept) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  assign start = (state == ISSUE);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_excitation_src.sv
// Self-checking bench for excitation_src: directed scenarios plus a randomized run
// compared against an arithmetic reference model of the pitch/noise rules.
module tb_excitation_src;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_tick;
  logic [7:0]  period_in;
  logic [7:0]  amp_in;
  logic        param_load;
  logic        filt_done;
  logic        overrun_clr;
  logic [15:0] sig_out;
  logic        start;
  logic        busy;
  logic        overrun;

  excitation_src dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .period_in(period_in),
    .amp_in(amp_in), .param_load(param_load), .filt_done(filt_done),
    .overrun_clr(overrun_clr), .sig_out(sig_out), .start(start),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  int sh_p, sh_a, act_p, act_a, cnt, lfsr, last_exp;

  task automatic check(input string tag, input integer obs, input integer exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sh_p = 0; sh_a = 0; act_p = 0; act_a = 0; cnt = 0; lfsr = 1; last_exp = 0;
  endtask

  task automatic model_tick(input bit ld, input int p, input int a);
    if (cnt == 0 || act_p == 0) begin
      act_p = sh_p;
      act_a = sh_a;
      if (act_p != 0) begin
        last_exp = act_a * 64;
        cnt = act_p - 1;
      end else begin
        last_exp = (lfsr % 2 == 1) ? act_a * 16 : -(act_a * 16);
        cnt = 0;
      end
    end else begin
      last_exp = 0;
      cnt = cnt - 1;
    end
    lfsr = ((lfsr * 2) % 131072) + (((lfsr / 65536) % 2) ^ ((lfsr / 8192) % 2));
    if (ld) begin
      sh_p = p;
      sh_a = a;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sample_tick = 1'b0; param_load = 1'b0; overrun_clr = 1'b0; filt_done = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic load(input int p, input int a);
    @(negedge clk);
    param_load = 1'b1; period_in = 8'(p); amp_in = 8'(a);
    @(negedge clk);
    param_load = 1'b0;
    sh_p = p; sh_a = a;
  endtask

  // Accepted tick; leaves the DUT in BUSY with filt_done low.
  task automatic tick_begin(input bit ld, input int p, input int a);
    @(negedge clk);
    sample_tick = 1'b1;
    if (ld) begin
      param_load = 1'b1; period_in = 8'(p); amp_in = 8'(a);
    end
    @(negedge clk);
    sample_tick = 1'b0; param_load = 1'b0;
    model_tick(ld, p, a);
    check("start_pulse", start, 1);
    check("sig_out", $signed(sig_out), last_exp);
    filt_done = 1'b0;
    @(negedge clk);
    check("start_one_cycle", start, 0);
    check("busy_in_ack", busy, 1);
    @(negedge clk);
  endtask

  task automatic tick_end(input int hold);
    repeat (hold) @(negedge clk);
    filt_done = 1'b1;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    check("return_idle", busy, 0);
    check("sig_hold", $signed(sig_out), last_exp);
  endtask

  task automatic tick(input bit ld, input int p, input int a);
    tick_begin(ld, p, a);
    tick_end(1);
  endtask

  task automatic drop(input bit clr, input int exp_ov);
    @(negedge clk);
    sample_tick = 1'b1; overrun_clr = clr;
    @(negedge clk);
    sample_tick = 1'b0; overrun_clr = 1'b0;
    check("drop_overrun", overrun, exp_ov);
    check("drop_no_start", start, 0);
    check("drop_sig_kept", $signed(sig_out), last_exp);
  endtask

  task automatic clear_overrun();
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("overrun_cleared", overrun, 0);
  endtask

  int voiced_seq [7]  = '{6400, 0, 0, 6400, 0, 0, 6400};
  int noise_seq  [4]  = '{160, -160, -160, -160};
  int pitch_seq  [12] = '{3200, 0, 0, 0, 0, 3200, 0, 3200, 0, 3200, 0, 3200};

  initial begin
    rst = 1'b1; sample_tick = 1'b0; param_load = 1'b0; overrun_clr = 1'b0;
    filt_done = 1'b1; period_in = 8'd0; amp_in = 8'd0;
    model_reset();
    #1;
    check("reset_sig", sig_out, 0);
    check("reset_start", start, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b0;

    // voiced period 3
    load(3, 100);
    for (int i = 0; i < 7; i++) begin
      tick(0, 0, 0);
      check($sformatf("voiced_seq%0d", i), $signed(sig_out), voiced_seq[i]);
    end

    // unvoiced noise from seed
    do_reset();
    load(0, 10);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0);
      check($sformatf("noise_seq%0d", i), $signed(sig_out), noise_seq[i]);
    end

    // overrun handling
    do_reset();
    load(4, 20);
    tick_begin(0, 0, 0);
    drop(0, 1);
    drop(1, 1);
    tick_end(0);
    clear_overrun();
    filt_done = 1'b0;
    drop(0, 1);
    filt_done = 1'b1;
    clear_overrun();
    tick(0, 0, 0);
    check("after_drop_nonboundary", $signed(sig_out), 0);

    // period change waits for the end of the pitch period
    do_reset();
    load(5, 50);
    for (int i = 0; i < 12; i++) begin
      tick(i == 1, 2, 50);
      check($sformatf("pitch_seq%0d", i + 1), $signed(sig_out), pitch_seq[i]);
    end

    // reset in the middle of a handshake
    do_reset();
    load(3, 100);
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0; filt_done = 1'b0;
    check("pre_reset_sig", $signed(sig_out), 6400);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_ack_start", start, 0);
    check("rst_ack_busy", busy, 0);
    check("rst_ack_sig", sig_out, 0);
    @(negedge clk);
    rst = 1'b0; filt_done = 1'b1;
    model_reset();
    tick(0, 0, 0);
    check("post_reset_sig", $signed(sig_out), 0);

    // coincident load while unvoiced with amp 0
    do_reset();
    tick(0, 0, 0);
    tick(1, 1, 255);
    check("coincident_old", $signed(sig_out), 0);
    tick(0, 0, 0);
    check("coincident_new", $signed(sig_out), 16320);
    tick(0, 0, 0);
    check("period1_every_tick", $signed(sig_out), 16320);

    // randomized run against the model
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int r;
      r = int'($urandom_range(0, 3));
      if (r == 0) begin
        load(int'($urandom_range(0, 4)), int'($urandom_range(0, 255)));
      end else begin
        bit ld;
        ld = ($urandom_range(0, 3) == 0);
        tick_begin(ld, int'($urandom_range(0, 4)), int'($urandom_range(0, 255)));
        if ($urandom_range(0, 3) == 0) begin
          drop(0, 1);
          tick_end(int'($urandom_range(0, 2)));
          clear_overrun();
        end else begin
          tick_end(int'($urandom_range(0, 2)));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
